cpu_regfile_dp: RTL and testbench
=================================

# cpu_regfile_dp

Parametrised register file and datapath for the tinycpu core. It holds the A, B, M and P registers of width WIDTH and the instruction register IR, and executes one register-transfer operation per accepted command. Memory-touching operations (load, store, fetch) run a req/ack handshake to the SRAM controller. It sits between cpu_control, which issues the commands, and the SRAM controller. It adds real register state and multi-cycle memory sequencing on top of the existing source/address multiplexing.

## Interface
- WIDTH, 8: data/address width of A, B, M, P, IR; legal range ≥ 2.
- PC_RESET, 0: reset value of P; must fit in WIDTH bits.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  command valid.
- op_ready  out  1  block can accept a command.
- op  in  4  command code (see Operation).
- imm  in  WIDTH  immediate for LDI.
- alu_res  in  WIDTH  ALU result for ALU.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req = 1.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data; valid with mem_ack.
- mem_ack  in  1  request complete.
- rA, rB, rM, rP, rIR  out  WIDTH  register contents.

## Operation
- A command is accepted on a rising edge where op_valid && op_ready.
- Single-cycle ops update registers on the accepting edge:
  - 0 NOP: no change.
  - 1 LDI: A ← imm.
  - 2 ALU: A ← alu_res.
  - 3 SWAB: A ↔ B, atomic.
  - 4 SWBM: B ↔ M, atomic.
  - 5 CPPA: A ← P.
  - 6 CPPM: M ← P.
  - 7 INCP: P ← P+1 mod 2^WIDTH.
  - 8 JMP: P ← M.
  - 12–15: reserved, executed as NOP.
- Memory ops:
  - 9 LD: A ← mem[M].
  - 10 ST: mem[M] ← A.
  - 11 FETCH: IR ← mem[P], then P ← P+1 mod 2^WIDTH.
- FSM has two states:
  - IDLE: op_ready = 1; mem_req = 0.
  - MEM: op_ready = 0; mem_req = 1.
  - IDLE → MEM on acceptance of op 9/10/11.
  - MEM → IDLE on an edge where mem_ack = 1.
- On the MEM→IDLE edge:
  - LD: A ← mem_rdata.
  - FETCH: IR ← mem_rdata and P incremented, on the same edge.
  - ST: no register change.
- Address mux:
  - mem_addr = M for LD/ST and P for FETCH, chosen by a registered select set at acceptance.
  - In IDLE the select is P.
  - No register can change while in MEM, so mem_addr, mem_wdata (= A) and mem_we are stable for the whole request.
- mem_ack is ignored in IDLE.
- Swaps and copies use pre-edge register values; P wraps from 2^WIDTH−1 to 0 with no flag.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - A = B = M = IR = 0; P = PC_RESET.
  - FSM = IDLE; mem_req = 0, mem_we = 0, mem_addr = PC_RESET, mem_wdata = 0, op_ready = 1 once rst_n is high.
- Single-cycle op: result visible on the r* outputs one cycle after the accepting edge. Back-to-back acceptance every cycle is allowed.
- Memory op accepted at edge E:
  - mem_req, mem_we and mem_addr are valid in the cycle after E.
  - If mem_ack is high in that cycle, completion happens at edge E+1, so minimum latency is 2 edges.
  - Each wait cycle adds 1.
  - op_ready returns to 1 in the cycle after the completing edge; a new command may be accepted at the next edge.
- mem_req is registered. It drops in the cycle after the ack edge, so each request is acknowledged exactly once.
- Reset asserted while in MEM:
  - mem_req drops asynchronously.
  - The pending op is abandoned; no register is updated from mem_rdata.
- op and imm are sampled only at acceptance; changes while op_ready = 0 are ignored.

## Test plan
- Reset with PC_RESET = 8'h10 → rP = 8'h10, rA/rB/rM/rIR = 0, mem_req = 0, op_ready = 1, mem_addr = 8'h10.
- Back-to-back sequence: LDI 8'h5A, SWAB, LDI 8'h33, SWBM, one per cycle → final A = 8'h33, B = 0, M = 8'h5A.
- LD with M = 8'h20, mem_ack held off 3 cycles, mem_rdata = 8'hC3 → mem_req high for 4 cycles with mem_addr = 8'h20 and mem_we = 0; A = 8'hC3; op_ready low throughout.
- FETCH with P = 8'hFF, ack on the first req cycle, rdata = 8'h91 → IR = 8'h91, P = 8'h00, total latency 2 edges.
- ST with A = 8'h7E, M = 8'h04 → mem_we = 1, mem_wdata = 8'h7E, mem_addr = 8'h04 stable until ack; no register changes.
- rst_n pulsed low mid-LD wait → mem_req falls immediately; A unchanged (0 after reset); a later ack is ignored.

Source files
------------

// File: rtl/cpu_regfile_dp.sv
// cpu_regfile_dp: tinycpu register file (A, B, M, P, IR) and datapath.
// Runs one register-transfer command per accepted op. Load, store and
// fetch go through a req/ack handshake with the SRAM controller, and the
// block holds every register steady while that request is outstanding.
module cpu_regfile_dp #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PC_RESET = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] alu_res,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] rA,
    output logic [WIDTH-1:0] rB,
    output logic [WIDTH-1:0] rM,
    output logic [WIDTH-1:0] rP,
    output logic [WIDTH-1:0] rIR
);

    // Command codes
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LDI   = 4'd1;
    localparam logic [3:0] OP_ALU   = 4'd2;
    localparam logic [3:0] OP_SWAB  = 4'd3;
    localparam logic [3:0] OP_SWBM  = 4'd4;
    localparam logic [3:0] OP_CPPA  = 4'd5;
    localparam logic [3:0] OP_CPPM  = 4'd6;
    localparam logic [3:0] OP_INCP  = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;
    localparam logic [3:0] OP_LD    = 4'd9;
    localparam logic [3:0] OP_ST    = 4'd10;
    localparam logic [3:0] OP_FETCH = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_t;

    // Which memory op is outstanding; decides what completion writes back.
    typedef enum logic [1:0] {
        MK_NONE  = 2'd0,
        MK_LD    = 2'd1,
        MK_ST    = 2'd2,
        MK_FETCH = 2'd3
    } mem_kind_t;

    // Program counter increment, wrapping silently at 2^WIDTH.
    function automatic logic [WIDTH-1:0] inc_w(input logic [WIDTH-1:0] v);
        return v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q,  state_d;
    mem_kind_t        kind_q,   kind_d;
    logic             sel_p_q,  sel_p_d;   // 1: address from P, 0: from M
    logic             we_q,     we_d;
    logic [WIDTH-1:0] a_q,  a_d;
    logic [WIDTH-1:0] b_q,  b_d;
    logic [WIDTH-1:0] m_q,  m_d;
    logic [WIDTH-1:0] p_q,  p_d;
    logic [WIDTH-1:0] ir_q, ir_d;

    // Next-state: single-cycle ops and memory-op launch in IDLE, write-back on ack in MEM.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        sel_p_d = sel_p_q;
        we_d    = we_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        p_d     = p_q;
        ir_d    = ir_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_NOP:  a_d = a_q;
                        OP_LDI:  a_d = imm;
                        OP_ALU:  a_d = alu_res;
                        OP_SWAB: begin
                            a_d = b_q;
                            b_d = a_q;
                        end
                        OP_SWBM: begin
                            b_d = m_q;
                            m_d = b_q;
                        end
                        OP_CPPA: a_d = p_q;
                        OP_CPPM: m_d = p_q;
                        OP_INCP: p_d = inc_w(p_q);
                        OP_JMP:  p_d = m_q;
                        OP_LD: begin
                            state_d = ST_MEM;
                            kind_d  = MK_LD;
                            sel_p_d = 1'b0;
                            we_d    = 1'b0;
                        end
                        OP_ST: begin
                            state_d = ST_MEM;
                            kind_d  = MK_ST;
                            sel_p_d = 1'b0;
                            we_d    = 1'b1;
                        end
                        OP_FETCH: begin
                            state_d = ST_MEM;
                            kind_d  = MK_FETCH;
                            sel_p_d = 1'b1;
                            we_d    = 1'b0;
                        end
                        // Codes 12..15 are reserved and behave as NOP.
                        default: a_d = a_q;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    case (kind_q)
                        MK_LD: a_d = mem_rdata;
                        MK_FETCH: begin
                            ir_d = mem_rdata;
                            p_d  = inc_w(p_q);
                        end
                        MK_ST:   a_d = a_q;
                        default: a_d = a_q;
                    endcase
                    state_d = ST_IDLE;
                    kind_d  = MK_NONE;
                    sel_p_d = 1'b1;
                    we_d    = 1'b0;
                end else begin
                    state_d = ST_MEM;
                end
            end
            default: begin
                state_d = ST_IDLE;
                kind_d  = MK_NONE;
                sel_p_d = 1'b1;
                we_d    = 1'b0;
            end
        endcase
    end

    // State, handshake controls and architectural registers; reset abandons any pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= MK_NONE;
            sel_p_q <= 1'b1;
            we_q    <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            m_q     <= {WIDTH{1'b0}};
            p_q     <= PC_RESET;
            ir_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            sel_p_q <= sel_p_d;
            we_q    <= we_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            p_q     <= p_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs come straight from flops (address through the registered select only).
    assign op_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_MEM);
    assign mem_we    = we_q;
    assign mem_addr  = sel_p_q ? p_q : m_q;
    assign mem_wdata = a_q;
    assign rA        = a_q;
    assign rB        = b_q;
    assign rM        = m_q;
    assign rP        = p_q;
    assign rIR       = ir_q;

endmodule

// File: tb/tb_cpu_regfile_dp.sv
// Self-checking bench for cpu_regfile_dp: directed scenarios with literal
// expectations plus randomized traffic checked against an op-level model.
module tb_cpu_regfile_dp;

    localparam int         W     = 8;
    localparam logic [7:0] PCRST = 8'h10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] imm = '0;
    logic [W-1:0] alu_res = '0;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic [W-1:0] rA, rB, rM, rP, rIR;

    cpu_regfile_dp #(.WIDTH(W), .PC_RESET(PCRST)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .imm(imm), .alu_res(alu_res),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rA(rA), .rB(rB), .rM(rM), .rP(rP), .rIR(rIR)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Reference model: architectural registers plus the outstanding memory op.
    logic [W-1:0] md_a, md_b, md_m, md_p, md_ir;
    logic         md_busy;
    logic [3:0]   md_kind;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_a = '0; md_b = '0; md_m = '0; md_ir = '0; md_p = PCRST;
        md_busy = 1'b0; md_kind = 4'd0;
    endtask

    // One clock edge of the tinycpu register-transfer semantics.
    task automatic model_step();
        logic [W-1:0] t;
        if (!md_busy) begin
            if (op_valid) begin
                case (op)
                    4'd1: md_a = imm;
                    4'd2: md_a = alu_res;
                    4'd3: begin t = md_a; md_a = md_b; md_b = t; end
                    4'd4: begin t = md_b; md_b = md_m; md_m = t; end
                    4'd5: md_a = md_p;
                    4'd6: md_m = md_p;
                    4'd7: md_p = md_p + 8'd1;
                    4'd8: md_p = md_m;
                    4'd9, 4'd10, 4'd11: begin md_busy = 1'b1; md_kind = op; end
                    default: ;
                endcase
            end
        end else if (mem_ack) begin
            if (md_kind == 4'd9) md_a = mem_rdata;
            if (md_kind == 4'd11) begin md_ir = mem_rdata; md_p = md_p + 8'd1; end
            md_busy = 1'b0;
        end
    endtask

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rA", {24'd0, rA}, {24'd0, md_a});
            check("rB", {24'd0, rB}, {24'd0, md_b});
            check("rM", {24'd0, rM}, {24'd0, md_m});
            check("rP", {24'd0, rP}, {24'd0, md_p});
            check("rIR", {24'd0, rIR}, {24'd0, md_ir});
            check("op_ready", {31'd0, op_ready}, {31'd0, !md_busy});
            check("mem_req", {31'd0, mem_req}, {31'd0, md_busy});
            check("mem_wdata", {24'd0, mem_wdata}, {24'd0, md_a});
            check("mem_addr", {24'd0, mem_addr},
                  {24'd0, (md_busy && md_kind != 4'd11) ? md_m : md_p});
            if (md_busy)
                check("mem_we", {31'd0, mem_we}, {31'd0, md_kind == 4'd10});
        end
    end

    // Drive one cycle's inputs (just after a falling edge), clock, and update the model.
    task automatic cyc(input logic v, input logic [3:0] o, input logic [W-1:0] im,
                       input logic ack, input logic [W-1:0] rd);
        op_valid = v; op = o; imm = im; alu_res = logic'($urandom_range(0, 255));
        mem_ack = ack; mem_rdata = rd;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    int req_cycles;
    int edges;

    initial begin
        model_reset();
        #12;
        // Reset values while rst_n is low.
        check("reset rP", {24'd0, rP}, 32'h10);
        check("reset rA", {24'd0, rA}, 32'h0);
        check("reset rIR", {24'd0, rIR}, 32'h0);
        check("reset mem_req", {31'd0, mem_req}, 32'h0);
        check("reset mem_we", {31'd0, mem_we}, 32'h0);
        check("reset mem_addr", {24'd0, mem_addr}, 32'h10);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        check("ready after reset", {31'd0, op_ready}, 32'h1);

        // Back-to-back LDI 5A, SWAB, LDI 33, SWBM.
        @(negedge clk);
        cyc(1'b1, 4'd1, 8'h5A, 1'b0, 8'h00);
        cyc(1'b1, 4'd3, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 4'd1, 8'h33, 1'b0, 8'h00);
        cyc(1'b1, 4'd4, 8'h00, 1'b0, 8'h00);
        check("b2b A", {24'd0, rA}, 32'h33);
        check("b2b B", {24'd0, rB}, 32'h00);
        check("b2b M", {24'd0, rM}, 32'h5A);

        // LD from M=20 with ack held off three cycles.
        cyc(1'b1, 4'd1, 8'h20, 1'b0, 8'h00);
        cyc(1'b1, 4'd3, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 4'd4, 8'h00, 1'b0, 8'h00);
        check("M set 20", {24'd0, rM}, 32'h20);
        cyc(1'b1, 4'd9, 8'h00, 1'b0, 8'h00);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            req_cycles++;
            check("ld addr", {24'd0, mem_addr}, 32'h20);
            check("ld we", {31'd0, mem_we}, 32'h0);
            check("ld ready low", {31'd0, op_ready}, 32'h0);
            cyc(1'b1, 4'd1, 8'hAA, req_cycles == 4, 8'hC3);
        end
        check("ld req cycles", req_cycles, 32'd4);
        check("ld A", {24'd0, rA}, 32'hC3);

        // FETCH at P=FF, ack on first request cycle.
        cyc(1'b1, 4'd1, 8'hFF, 1'b0, 8'h00);
        cyc(1'b1, 4'd3, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 4'd4, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 4'd8, 8'h00, 1'b0, 8'h00);
        check("P set FF", {24'd0, rP}, 32'hFF);
        cyc(1'b1, 4'd11, 8'h00, 1'b0, 8'h00);
        edges = 1;
        for (int i = 0; i < 20; i++) begin
            if (op_ready) break;
            check("fetch addr", {24'd0, mem_addr}, 32'hFF);
            cyc(1'b0, 4'd0, 8'h00, 1'b1, 8'h91);
            edges++;
        end
        check("fetch latency", edges, 32'd2);
        check("fetch IR", {24'd0, rIR}, 32'h91);
        check("fetch P wrap", {24'd0, rP}, 32'h00);

        // ST A=7E to M=04 with two wait cycles.
        cyc(1'b1, 4'd1, 8'h04, 1'b0, 8'h00);
        cyc(1'b1, 4'd3, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 4'd4, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 4'd1, 8'h7E, 1'b0, 8'h00);
        cyc(1'b1, 4'd10, 8'h00, 1'b0, 8'h00);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            req_cycles++;
            check("st we", {31'd0, mem_we}, 32'h1);
            check("st wdata", {24'd0, mem_wdata}, 32'h7E);
            check("st addr", {24'd0, mem_addr}, 32'h04);
            cyc(1'b1, 4'd2, 8'h11, req_cycles == 3, 8'hEE);
        end
        check("st req cycles", req_cycles, 32'd3);
        check("st A kept", {24'd0, rA}, 32'h7E);
        check("st M kept", {24'd0, rM}, 32'h04);

        // Reset in the middle of an LD wait; the late ack must be ignored.
        cyc(1'b1, 4'd9, 8'h00, 1'b0, 8'h00);
        cyc(1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst mem_req", {31'd0, mem_req}, 32'h0);
        check("rst A", {24'd0, rA}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 4'd0, 8'h00, 1'b1, 8'hEE);
        check("late ack A", {24'd0, rA}, 32'h0);
        check("late ack ready", {31'd0, op_ready}, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), $urandom_range(0, 4) < 2,
                8'($urandom_range(0, 255)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
